pipe_hazard_ctrl: RTL

- Pipeline control unit for the 5-stage WISC core. Sits beside the decoder.
- Takes the decode-stage register usage, the destination info of the EX/MEM/WB stages, branch resolution, memory stall handshakes, and the decoder's halt/siic/rti flags.
- Drives the stall, flush and bubble controls of every pipeline register and the PC.
- Sequences the halt drain and the SIIC/RTI redirect, including EPC storage.

---
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage WISC core: hazard stalls, branch flush,
// SIIC/RTI redirect with EPC, and the HALT drain sequence.
module pipe_hazard_ctrl #(
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned DRAIN_CYC = 3,
    parameter logic [15:0] EXC_VEC   = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_use,
    input  logic        id_rt_use,
    input  logic        id_halt,
    input  logic        id_siic,
    input  logic        id_rti,
    input  logic [15:0] id_pc_inc,
    input  logic        ex_reg_wrt,
    input  logic        mem_reg_wrt,
    input  logic        wb_reg_wrt,
    input  logic [2:0]  ex_wr_reg,
    input  logic [2:0]  mem_wr_reg,
    input  logic [2:0]  wb_wr_reg,
    input  logic        ex_fwd,
    input  logic        br_taken,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        memwb_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pc_redirect,
    output logic [15:0] pc_target,
    output logic [15:0] epc,
    output logic        halted,
    output logic        err
);

    localparam int unsigned CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   epc_q, epc_d;
    logic          in_exc_q, in_exc_d;
    logic          err_q, err_d;

    logic [4:0]    stall;
    logic          hit_ex, hit_mem, hit_wb, hazard;

    function automatic logic src_hit(input logic wrt, input logic [2:0] dst);
        return wrt && ((id_rs_use && (id_rs == dst)) || (id_rt_use && (id_rt == dst)));
    endfunction

    assign hit_ex  = src_hit(ex_reg_wrt, ex_wr_reg);
    assign hit_mem = src_hit(mem_reg_wrt, mem_wr_reg);
    assign hit_wb  = src_hit(wb_reg_wrt, wb_wr_reg);
    // With forwarding only a non-forwardable EX result (load) blocks decode.
    assign hazard  = id_valid && (FWD_EN ? (hit_ex && !ex_fwd) : (hit_ex || hit_mem || hit_wb));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        epc_d       = epc_q;
        in_exc_d    = in_exc_q;
        err_d       = err_q;
        stall       = '0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (dmem_stall) begin
                        stall = '1;
                    end else if (br_taken) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hazard) begin
                        stall       = 5'b11000;
                        idex_bubble = 1'b1;
                    end else if (id_valid && id_siic) begin
                        if (in_exc_q) begin
                            err_d = 1'b1;
                        end else begin
                            epc_d       = id_pc_inc;
                            in_exc_d    = 1'b1;
                            pc_redirect = 1'b1;
                            pc_target   = EXC_VEC;
                            ifid_flush  = 1'b1;
                        end
                    end else if (id_valid && id_rti) begin
                        if (!in_exc_q) begin
                            err_d = 1'b1;
                        end else begin
                            in_exc_d    = 1'b0;
                            pc_redirect = 1'b1;
                            pc_target   = epc_q;
                            ifid_flush  = 1'b1;
                        end
                    end else if (id_valid && id_halt) begin
                        state_d    = S_DRAIN;
                        cnt_d      = CW'(DRAIN_CYC);
                        stall      = 5'b10000;
                        ifid_flush = 1'b1;
                    end else if (imem_stall) begin
                        stall      = 5'b10000;
                        ifid_flush = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dmem_stall) begin
                        stall = '1;
                    end else begin
                        stall       = 5'b10000;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        cnt_d       = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_d = S_HALTED;
                    end
                end
                default: stall = '1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            epc_q    <= '0;
            in_exc_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            epc_q    <= epc_d;
            in_exc_q <= in_exc_d;
            err_q    <= err_d;
        end
    end

    assign {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall} = stall;
    assign epc    = epc_q;
    assign halted = (state_q == S_HALTED);
    assign err    = err_q;

endmodule
